// File: rtl/joy_db15_pkg.sv
// Shared constants, state encoding and frame packing for the DB15 splitter emulation.
package joy_db15_pkg;

    localparam int NBITS_DEF   = 24;
    localparam int PLAYER_BITS = 12;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    // Bit positions inside one 12-bit player word, bit0 first on the wire
    localparam int BTN_R  = 0;
    localparam int BTN_L  = 1;
    localparam int BTN_DN = 2;
    localparam int BTN_UP = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_D  = 7;
    localparam int BTN_E  = 8;
    localparam int BTN_F  = 9;
    localparam int BTN_S  = 10;
    localparam int BTN_LB = 11;

    // The 74HC165 chain sees pulled-up buttons, so the wire image is inverted
    function automatic logic [2*PLAYER_BITS-1:0] pack_frame(
        input logic [PLAYER_BITS-1:0] j1,
        input logic [PLAYER_BITS-1:0] j2
    );
        return {~j2, ~j1};
    endfunction

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Two-flop synchronizer plus edge register; all flops idle high like the pulled-up strobes.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/joy_db15_tx.sv
// Emulated DB15 splitter: answers JOY_LOAD/JOY_CLK with the two joystick words serialized LSB first.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int NBITS   = NBITS_DEF,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PLAYER_BITS-1:0] joystick1,
    input  logic [PLAYER_BITS-1:0] joystick2,
    input  logic                   JOY_LOAD,
    input  logic                   JOY_CLK,
    output logic                   JOY_DATA,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   link_active
);
    localparam int BW = $clog2(NBITS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST = BW'(NBITS - 1);
    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

    logic load_s, load_rise, load_fall;
    logic clk_s, clk_rise, clk_fall;
    logic unused_sync;

    sync_edge u_load_sync (
        .clk  (clk),
        .reset(reset),
        .din  (JOY_LOAD),
        .q    (load_s),
        .rise (load_rise),
        .fall (load_fall)
    );

    sync_edge u_clk_sync (
        .clk  (clk),
        .reset(reset),
        .din  (JOY_CLK),
        .q    (clk_s),
        .rise (clk_rise),
        .fall (clk_fall)
    );

    assign unused_sync = ^{load_rise, clk_s, clk_fall};

    state_t          state_q, state_d;
    logic [NBITS-1:0] sr;
    logic [BW-1:0]   bit_cnt;
    logic [CW-1:0]   wd_cnt;
    logic            do_load, do_shift, do_last;

    always_comb begin
        state_d  = state_q;
        do_load  = ~load_s;
        do_shift = 1'b0;
        do_last  = 1'b0;
        case (state_q)
            IDLE:  ;
            LOAD:  if (load_s) state_d = SHIFT;
            SHIFT: begin
                do_shift = load_s & clk_rise;
                do_last  = do_shift && (bit_cnt == LAST);
                if (do_last) state_d = DONE;
            end
            DONE:  ;
            default: state_d = IDLE;
        endcase
        // A low load level overrides everything, including a coincident shift
        if (!load_s) state_d = LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sr         <= '1;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= do_last;
            if (do_load) begin
                sr      <= NBITS'(pack_frame(joystick1, joystick2));
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (do_shift) begin
                sr      <= {1'b1, sr[NBITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state_q == DONE && clk_rise) begin
                overrun <= 1'b1;
            end
        end
    end

    // Watchdog starts saturated so the link reads inactive until the first load
    always_ff @(posedge clk) begin
        if (reset)                wd_cnt <= WD_MAX;
        else if (load_fall)       wd_cnt <= '0;
        else if (wd_cnt < WD_MAX) wd_cnt <= wd_cnt + 1'b1;
    end

    assign link_active = (wd_cnt < WD_MAX);
    assign JOY_DATA    = (state_q == DONE) ? 1'b1 : sr[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: scoreboard of expected serial bits, frame/overrun/watchdog checks.
module tb_joy_db15_tx;
    localparam int TO   = 2000;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] joystick1 = '0;
    logic [11:0] joystick2 = '0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_CLK = 1'b0;
    logic        JOY_DATA, frame_done, overrun, link_active;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fd0;
    bit exp_q[$];

    always #5 clk = ~clk;

    joy_db15_tx #(.NBITS(24), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_CLK    (JOY_CLK),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .overrun    (overrun),
        .link_active(link_active)
    );

    always @(posedge clk) if (!reset && frame_done) fd_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wire image is active-low, P1 bit0 first, then P2
    task automatic set_expect(input logic [11:0] j1, input logic [11:0] j2);
        logic [23:0] f;
        f = {j2, j1};
        exp_q.delete();
        for (int i = 0; i < 24; i++) exp_q.push_back(!f[i]);
    endtask

    task automatic load_pulse(input logic [11:0] j1, input logic [11:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        set_expect(j1, j2);
        JOY_LOAD = 1'b0;
        tick(HALF);
        JOY_LOAD = 1'b1;
        tick(HALF);
    endtask

    task automatic clk_pulse();
        JOY_CLK = 1'b1;
        tick(HALF);
        JOY_CLK = 1'b0;
        tick(HALF);
    endtask

    task automatic shift_bits(input int n);
        bit e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("bit%0d", i), {31'd0, JOY_DATA}, {31'd0, e});
            end
            clk_pulse();
        end
    endtask

    initial begin
        logic [11:0] r1, r2;
        tick(5);
        reset = 1'b0;
        tick(1000);
        check("rst_data", {31'd0, JOY_DATA}, 32'd1);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_link", {31'd0, link_active}, 32'd0);
        check("rst_fd_cnt", fd_cnt, 32'd0);

        // Edge patterns: first and last bits low, middle all high
        load_pulse(12'h001, 12'h800);
        check("link_after_load", {31'd0, link_active}, 32'd1);
        fd0 = fd_cnt;
        shift_bits(24);
        check("frame_done_once", fd_cnt - fd0, 32'd1);
        check("done_data_idle", {31'd0, JOY_DATA}, 32'd1);
        check("no_overrun_yet", {31'd0, overrun}, 32'd0);

        clk_pulse();
        clk_pulse();
        check("overrun_data", {31'd0, JOY_DATA}, 32'd1);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_no_fd", fd_cnt - fd0, 32'd1);

        load_pulse(12'hA5C, 12'h3F0);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        fd0 = fd_cnt;
        shift_bits(10);

        // Abort mid-frame, with joystick1 changing while load is held low
        joystick1 = 12'h123;
        JOY_LOAD = 1'b0;
        tick(HALF);
        joystick1 = 12'hFE7;
        set_expect(12'hFE7, joystick2);
        tick(HALF);
        JOY_LOAD = 1'b1;
        tick(HALF);
        check("abort_no_fd", fd_cnt - fd0, 32'd0);
        shift_bits(24);
        check("restart_fd", fd_cnt - fd0, 32'd1);

        for (int f = 0; f < 20; f++) begin
            r1 = 12'($urandom);
            r2 = 12'($urandom);
            fd0 = fd_cnt;
            load_pulse(r1, r2);
            shift_bits(24);
            check($sformatf("rand_fd%0d", f), fd_cnt - fd0, 32'd1);
        end

        for (int k = 0; k < 3; k++) begin
            load_pulse(12'h000, 12'h000);
            tick(TO / 2);
            check($sformatf("link_periodic%0d", k), {31'd0, link_active}, 32'd1);
        end

        // Fall reaches the watchdog 3 edges after the pin, then TIMEOUT edges more
        JOY_LOAD = 1'b0;
        tick(5);
        JOY_LOAD = 1'b1;
        tick(TO - 3);
        check("link_before_timeout", {31'd0, link_active}, 32'd1);
        tick(1);
        check("link_at_timeout", {31'd0, link_active}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Emulates the external DB15 splitter board: the 74HC165 shift-register chain that the core's DB15 joystick reader polls over the USER port. It takes two 12-bit active-high joystick words and answers the reader's JOY_LOAD/JOY_CLK strobes with serial JOY_DATA. It lets the bench, or a loopback build, exercise the reader, the joy_0/joy_1 muxing and USER_OSD without hardware. It also reports frame completion, over-clocking and link activity.

## Interface
- NBITS, 24: bits per frame (2 players × 12).
- TIMEOUT, 1_000_000: clk cycles without a load before link_active drops.
- clk  in  1  system clock, 40–50 MHz (CLK_JOY domain).
- reset  in  1  synchronous, active-high.
- joystick1  in  12  player-1 state, active-high, {L,S,F,E,D,C,B,A,U,D,L,R}, bit0 = R.
- joystick2  in  12  player-2 state, same layout.
- JOY_LOAD  in  1  async from reader; low = parallel load (SH/LD#).
- JOY_CLK  in  1  async from reader; rising edge = shift.
- JOY_DATA  out  1  serial data, active-low buttons, idle 1.
- frame_done  out  1  one-cycle pulse when the NBITS-th shift completes.
- overrun  out  1  sticky: shift edge arrived after the frame was exhausted; cleared by the next load.
- link_active  out  1  a load has been seen within the last TIMEOUT cycles.

## Operation
- JOY_LOAD and JOY_CLK each pass through a 2-flop synchronizer plus an edge register. The block works on the synchronized levels load_s and clk_rise.
- Shift register sr[NBITS-1:0] holds active-low data: sr = {~joystick2, ~joystick1}. JOY_DATA = sr[0].
- Serial order is LSB first: P1 R, L, D, U, A…, then P2 bit0…bit11. Shift inserts 1 at sr[NBITS-1], matching SER tied high.
- State machine:
  - IDLE (reset state): sr = all 1s. load_s=0 → LOAD.
  - LOAD: sr reloads from the inputs every cycle; bit_cnt = 0; overrun cleared. load_s=1 → SHIFT, holding the last loaded value.
  - SHIFT: on each clk_rise, sr shifts right and bit_cnt increments. When bit_cnt reaches NBITS-1 and clk_rise occurs, frame_done pulses → DONE.
  - DONE: JOY_DATA = 1. clk_rise sets overrun. load_s=0 → LOAD.
- load_s=0 has priority in every state; a load mid-frame aborts the frame with no frame_done.
- If clk_rise coincides with load_s=0, the load wins and no shift happens.
- clk_rise in IDLE is ignored.
- Watchdog: a counter of width $clog2(TIMEOUT+1) is cleared on the load_s falling edge and saturates at TIMEOUT. link_active = (count < TIMEOUT).

## Timing
- Reset values: JOY_DATA=1, frame_done=0, overrun=0, link_active=0, state IDLE, sr all 1s, watchdog counter = TIMEOUT. Synchronizer flops reset to 1.
- Pin edge to internal action: 3 clk cycles (2 sync + 1 edge).
- JOY_DATA changes on the clk edge after clk_rise is registered. Worst-case pin-to-pin delay: 4 clk cycles.
- The reader must hold JOY_CLK high and low for at least 4 clk cycles each, and JOY_LOAD low for at least 3 cycles. Shorter pulses may be missed; this is not flagged.
- After load_s rises, the first bit (P1 R) is already on JOY_DATA before any shift.
- frame_done asserts in the same cycle sr performs the last shift.
- Input changes during LOAD are tracked; changes during SHIFT/DONE are ignored until the next load.

## Structure
- Package joy_db15_pkg: NBITS_DEF=24, PLAYER_BITS=12, state enum {IDLE, LOAD, SHIFT, DONE}, bit-index constants for R/L/D/U/A…S/L.
- Sub-module sync_edge: a 2-flop synchronizer with rise/fall outputs, reset to 1. It is instantiated for JOY_LOAD and JOY_CLK.
- Everything else lives in joy_db15_tx.

## Test plan
- Reset, no strobes → JOY_DATA=1, link_active=0, all outputs at reset values after 1000 cycles.
- joystick1=12'h001, joystick2=12'h800; load pulse; 24 clocks at 1 MHz → bits 0,1×22,0, then frame_done one pulse.
- Full frame followed by 2 extra JOY_CLK edges → JOY_DATA=1, overrun=1. The next load clears overrun.
- Load asserted after 10 shifts → no frame_done; restart yields the first bit again. joystick1 change during LOAD is reflected.
- Load every 16 ms at 50 MHz with TIMEOUT=1_000_000 → link_active=1. Stop loads → link_active falls exactly TIMEOUT cycles after the last load_s fall.
- Loopback with joy_db15 reader, random joysticks over 100 frames → JOYDB15_1/2 match joystick1/2 each frame.
